// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
// Holds the FSM encoding and the one-hot grant builder.
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Widest requester count supported; callers cast the result down to NUM_REQ.
  localparam int MAX_REQ   = 8;
  localparam int MAX_REQ_W = 3;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_REQ_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. Rotate, priority-encode, un-rotate.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [REQ_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] w_rot;
  logic [REQ_W-1:0]   w_pe;
  logic [REQ_W:0]     w_sum;

  // Bit i of w_rot is req[(i + ptr) mod NUM_REQ].
  assign w_rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    w_pe = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pe = REQ_W'(i);
    end
  end

  assign w_sum = {1'b0, w_pe} + {1'b0, ptr};
  assign idx   = (w_sum >= (REQ_W+1)'(NUM_REQ)) ? REQ_W'(w_sum - (REQ_W+1)'(NUM_REQ))
                                                : w_sum[REQ_W-1:0];
  assign any   = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ
// producers; each grant lasts up to MAX_BURST words or until the owner drops valid.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  localparam int REQ_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     fifo_full,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [0:0]         r_state;
  logic [REQ_W-1:0]   r_owner;
  logic [REQ_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [CNT_W-1:0]   r_burst_cnt;

  logic [REQ_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_own_valid;
  logic [WIDTH-1:0]   w_own_data;
  logic               w_busy;
  logic               w_xfer;
  logic               w_last;
  logic [REQ_W-1:0]   w_next_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_comb begin
    w_own_valid = 1'b0;
    w_own_data  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r_grant[r]) begin
        w_own_valid = req_valid[r];
        w_own_data  = req_data[r*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake: a word moves when the owner's req_valid and req_ready are both
  // high in the same cycle; ready depends only on grant and fifo_full, never on
  // valid. The producer keeps data stable while valid is high and ready is low.
  assign w_busy     = (r_state == ST_BURST);
  assign w_xfer     = w_busy & w_own_valid & ~fifo_full & ~reset;
  assign w_last     = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
  assign w_next_ptr = (r_owner == REQ_W'(NUM_REQ - 1)) ? '0 : r_owner + REQ_W'(1);

  assign req_ready  = (w_busy & ~fifo_full & ~reset) ? r_grant : '0;
  assign fifo_wr_en = w_xfer;
  assign fifo_wdata = w_xfer ? w_own_data : '0;
  assign grant      = r_grant;
  assign busy       = w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_burst_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_pick_any) begin
        r_state     <= ST_BURST;
        r_owner     <= w_pick_idx;
        r_grant     <= NUM_REQ'(onehot(MAX_REQ_W'(w_pick_idx)));
        r_burst_cnt <= '0;
      end
    end else begin
      // A stalled word (fifo_full) neither counts nor ends the burst.
      if (!w_own_valid || (w_xfer && w_last)) begin
        r_state     <= ST_IDLE;
        r_grant     <= '0;
        r_rr_ptr    <= w_next_ptr;
        r_burst_cnt <= '0;
      end else if (w_xfer) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then randomized producers,
// checked cycle by cycle against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wdata;
  logic           fifo_full;
  logic [N-1:0]   grant;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, where the search starts, words so far.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_words = 0;

  bit         src_valid[N];
  int         remain[N];
  int         sent[N];
  logic [W-1:0] base[N];
  bit         hold[N];
  bit         accepted[N];
  bit         rst_in    = 1'b1;
  bit         full_in   = 1'b0;
  int         full_at   = -1;
  int         full_left = 0;
  int         rst_req   = -1;
  int         rst_word  = -1;
  bit         rst_done  = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           ord_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int r);
    return base[r] + W'(sent[r]);
  endfunction

  task automatic apply();
    for (int r = 0; r < N; r++) begin
      req_valid[r]       = src_valid[r];
      req_data[r*W +: W] = word_of(r);
    end
    reset     = rst_in;
    fifo_full = full_in;
  endtask

  task automatic model_edge();
    bit found;
    if (rst_in) begin
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_words = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && src_valid[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_words = 0;
        ord_q.push_back(m_owner);
      end
    end else if (!src_valid[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end else if (!full_in) begin
      m_words++;
      if (m_words == MB) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    bit           e_wr;
    logic [W-1:0] e_data;
    apply();
    #1;
    e_grant = m_busy ? N'(1 << m_owner) : '0;
    e_wr    = m_busy && src_valid[m_owner] && !full_in && !rst_in;
    e_ready = (m_busy && !full_in && !rst_in) ? e_grant : '0;
    e_data  = e_wr ? word_of(m_owner) : '0;
    chk("grant", grant, e_grant);
    chk("busy", busy, m_busy);
    chk("req_ready", req_ready, e_ready);
    chk("fifo_wr_en", fifo_wr_en, e_wr);
    chk("fifo_wdata", fifo_wdata, e_data);
    chk("grant_onehot0", $onehot0(grant), 1);
    for (int r = 0; r < N; r++) accepted[r] = e_wr && (m_owner == r);
    if (e_wr) exp_q.push_back(e_data);
    if (fifo_wr_en === 1'b1) got_q.push_back(fifo_wdata);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_src(input int r, input logic [W-1:0] b, input int count);
    base[r]   = b;
    sent[r]   = 0;
    remain[r] = count;
  endtask

  task automatic run(input int max_cyc, input bit rnd);
    int cyc;
    int left;
    cyc      = 0;
    rst_done = 1'b0;
    left     = 0;
    for (int r = 0; r < N; r++) left += remain[r];
    while (left > 0 && cyc < max_cyc && !rst_done) begin
      for (int r = 0; r < N; r++) begin
        if (!hold[r]) src_valid[r] = (remain[r] > 0) && (!rnd || $urandom_range(0, 3) != 0);
      end
      if (rnd) full_in = ($urandom_range(0, 4) == 0);
      else if (full_at >= 0 && sent[0] == full_at && full_left > 0) begin
        full_in = 1'b1;
        full_left--;
      end else full_in = 1'b0;
      rst_in = 1'b0;
      if (rst_word >= 0 && sent[rst_req] == rst_word && m_busy && m_owner == rst_req) begin
        rst_in   = 1'b1;
        rst_word = -1;
        rst_done = 1'b1;
      end
      tick();
      left = 0;
      for (int r = 0; r < N; r++) begin
        if (accepted[r]) begin
          sent[r]++;
          remain[r]--;
        end
        hold[r] = src_valid[r] && !accepted[r];
        left += remain[r];
      end
      cyc++;
    end
    if (!rst_done) chk("all_words_sent", left, 0);
    for (int r = 0; r < N; r++) begin
      src_valid[r] = 1'b0;
      hold[r]      = 1'b0;
    end
    full_in = 1'b0;
    rst_in  = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    for (int r = 0; r < N; r++) begin
      src_valid[r] = 1'b0;
      hold[r]      = 1'b0;
      remain[r]    = 0;
      sent[r]      = 0;
      base[r]      = '0;
    end
    full_in = 1'b0;
    rst_in  = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    exp_q.delete();
    got_q.delete();
    ord_q.delete();
  endtask

  task automatic sb_check();
    chk("sb_len", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk("sb_word", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic ord_check(input int exp_ord[]);
    chk("order_len", ord_q.size(), exp_ord.size());
    for (int i = 0; i < exp_ord.size() && i < ord_q.size(); i++) chk("order", ord_q[i], exp_ord[i]);
    ord_q.delete();
  endtask

  initial begin
    for (int r = 0; r < N; r++) begin
      src_valid[r] = 1'b0;
      hold[r]      = 1'b0;
      remain[r]    = 0;
      sent[r]      = 0;
      base[r]      = '0;
    end
    apply();
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Single requester, six words: 4-word burst, idle cycle, 2-word burst.
    set_src(1, 8'hA0, 6);
    run(60, 1'b0);
    chk("t2_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk("t2_word", got_q[i], 32'hA0 + i);
    ord_check('{1, 1});
    sb_check();

    // Round-robin with all four valid continuously.
    do_reset();
    for (int r = 0; r < N; r++) set_src(r, W'(r * 16), 8);
    run(200, 1'b0);
    ord_check('{0, 1, 2, 3, 0, 1, 2, 3});
    sb_check();

    // Back-pressure: full for 3 cycles after word 2 of requester 0.
    do_reset();
    set_src(0, 8'h40, 4);
    full_at   = 2;
    full_left = 3;
    run(60, 1'b0);
    full_at = -1;
    chk("t4_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t4_word", got_q[i], 32'h40 + i);
    sb_check();

    // Early release: requester 2 drops after 2 words, requester 3 beats 0.
    do_reset();
    set_src(1, 8'h10, 1);
    run(30, 1'b0);
    ord_q.delete();
    set_src(2, 8'h20, 2);
    set_src(3, 8'h30, 2);
    set_src(0, 8'h00, 2);
    run(80, 1'b0);
    ord_check('{2, 3, 0});
    sb_check();

    // Reset during word 2 of a burst from requester 1.
    do_reset();
    set_src(1, 8'h50, 4);
    rst_req  = 1;
    rst_word = 2;
    run(60, 1'b0);
    chk("t6_reset_fired", rst_done, 1);
    chk("t6_words_before_reset", got_q.size(), 2);
    sb_check();
    ord_q.delete();
    set_src(0, 8'h60, 2);
    remain[1] = 2;
    run(60, 1'b0);
    ord_check('{0, 1});
    sb_check();

    // Randomized producers and back-pressure.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int r = 0; r < N; r++) set_src(r, W'($urandom_range(0, 255)), $urandom_range(0, 14));
      run(1500, 1'b1);
      sb_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
